div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Request scheduler that sits directly upstream of the sequential divider core, and also collects its results.
- Accepts dividend/denominator pairs over a valid/ready interface into a small FIFO.
- Issues one operation at a time to the divider using start/rdy, then holds the result on a valid/ready output until it is consumed.
- Decouples producers from the divider's multi-cycle latency.

Parameters:
- N, 4, denominator/quotient/remainder width; dividend is 2N.
- DEPTH, 4, request FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&&in_ready
- in_num  in  2N  dividend
- in_denom  in  N  denominator
- div_num  out  2N  dividend to divider
- div_denom  out  N  denominator to divider
- div_start  out  1  one-cycle start pulse to divider
- div_rdy  in  1  divider done
- div_quotient  in  N  divider quotient
- div_remainder  in  N  divider remainder
- div_overflow  in  1  divider overflow flag
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&&out_ready
- out_quotient  out  N  result quotient
- out_remainder  out  N  result remainder
- out_overflow  out  1  result overflow
- count  out  clog2(DEPTH)+1  FIFO occupancy, excluding the in-flight operation

Behaviour:
- Reset (async, rst=1): FIFO empty, count=0, state=IDLE, div_start=0, div_num=0, div_denom=0, out_valid=0, out_*=0, rdy_q=0. in_ready=1 after reset.
- in_ready = !full. There is no push-bypass when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop: both happen, count is unchanged. Pop uses occupancy at cycle start, so an item pushed into an empty FIFO is not popped in the same cycle.
- rdy_q is a register of div_rdy, updated every cycle. Done event = div_rdy && !rdy_q (rising edge).
- FSM:
  - IDLE: if FIFO is non-empty, pop the head into div_num/div_denom and go to ISSUE.
  - ISSUE: div_start=1 for exactly this cycle; go to WAIT.
  - WAIT: on the done event, register div_quotient/div_remainder/div_overflow into out_*, set out_valid=1, and go to HOLD.
  - HOLD: out_* are stable. On out_valid&&out_ready, clear out_valid. If the FIFO is non-empty, pop the next entry and go to ISSUE; otherwise go to IDLE.
- div_num/div_denom stay constant from the pop until the next pop. The divider sees stable operands for the whole operation.
- Latency: a request accepted at edge t into an empty, idle block is popped at t+1, and div_start is high during cycle t+1→t+2. out_valid rises on the edge following the divider's done edge.
- No reordering: results leave in request order. At most one operation is in flight.
- out_ready is ignored outside HOLD. out_* change only on the WAIT→HOLD capture.
- Reset mid-operation: everything aborts to the reset values. The divider shares rst and is aborted too. Queued requests are lost.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined: in IDLE/HOLD, a popped entry with denom==0 is not issued (no div_start). The state machine goes directly to HOLD on the next edge with out_quotient={N{1'b1}}, out_remainder=num[N-1:0], out_overflow=1, out_valid=1.
- Not defined: zero denominators are issued to the divider like any other request, and the divider's outputs are forwarded unchanged.

Test Plan:
- Basic divide, N=4: push num=8'd100, denom=4'd7, out_ready=1 → exactly one div_start pulse; out_quotient=14, out_remainder=2, out_overflow=0, out_valid for one cycle.
- Overflow: push num=8'hF0, denom=4'd3 → out_overflow=1; the next request still completes normally.
- Backpressure/full, DEPTH=4: out_ready=0, push 6 back-to-back → first 5 accepted (1 in flight + 4 queued), count=4, in_ready=0. Holding out_ready=0 for 10 cycles keeps out_* stable. Then out_ready=1 → 5 results in order, count drains to 0.
- Ordering: push (100,7), (45,4), (200,13) → results (14,2), (11,1), (15,5) in that order.
- Reset mid-operation: assert rst during WAIT → div_start=0, out_valid=0, count=0 immediately. After release, new request (9,2) → (4,1).
- Zero denominator: push (8'h5A, 0) → with DIV_ZERO_BYPASS_EN: no div_start, q=4'hF, r=4'hA, overflow=1; without it: a single div_start is issued and the divider outputs are forwarded.

Source files
------------

// File: rtl/div_sched_if.sv
// Request and result streams of the divider scheduler: valid/ready request
// channel (dividend/denominator) and valid/ready result channel.
interface div_sched_if #(
  parameter int N = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   in_num;
  logic [N-1:0]     in_denom;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_quotient;
  logic [N-1:0]     out_remainder;
  logic             out_overflow;

  modport slave (
    input  in_valid, in_num, in_denom, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_overflow
  );

  modport master (
    output in_valid, in_num, in_denom, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_overflow
  );
endinterface

// File: rtl/div_sched.sv
// Request FIFO + issue/collect FSM in front of a sequential divider core.
// Optional DIV_ZERO_BYPASS_EN: zero denominators are answered locally without issuing.
module div_sched #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  div_sched_if.slave             bus,
  output logic [2*N-1:0]         div_num,
  output logic [N-1:0]           div_denom,
  output logic                   div_start,
  input  logic                   div_rdy,
  input  logic [N-1:0]           div_quotient,
  input  logic [N-1:0]           div_remainder,
  input  logic                   div_overflow,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t          state;
  logic [2*N-1:0]  num_mem   [DEPTH];
  logic [N-1:0]    denom_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            rdy_q;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            done;
  logic            head_zero;
  logic [2*N-1:0]  head_num;
  logic [N-1:0]    head_denom;

  // Saturated quotient reported for a locally answered divide-by-zero.
  function automatic logic [N-1:0] sat_quotient();
    return {N{1'b1}};
  endfunction

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign head_num     = num_mem[rd_ptr];
  assign head_denom   = denom_mem[rd_ptr];
  assign head_zero    = BYPASS_EN && (head_denom == '0);
  assign done         = div_rdy && !rdy_q;

  // Pop decision uses occupancy at cycle start, so a fresh push is never popped same cycle.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == IDLE)
        pop = 1'b1;
      else if (state == HOLD && bus.out_ready)
        pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      num_mem[wr_ptr]   <= bus.in_num;
      denom_mem[wr_ptr] <= bus.in_denom;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      rdy_q             <= 1'b0;
      div_start         <= 1'b0;
      div_num           <= '0;
      div_denom         <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_quotient  <= '0;
      bus.out_remainder <= '0;
      bus.out_overflow  <= 1'b0;
    end else begin
      rdy_q     <= div_rdy;
      div_start <= 1'b0;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        div_num   <= head_num;
        div_denom <= head_denom;
      end
      count <= count + CW'(push) - CW'(pop);

      case (state)
        IDLE: begin
          if (pop) begin
            if (head_zero) begin
              bus.out_quotient  <= sat_quotient();
              bus.out_remainder <= head_num[N-1:0];
              bus.out_overflow  <= 1'b1;
              bus.out_valid     <= 1'b1;
              state             <= HOLD;
            end else begin
              div_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (done) begin
            bus.out_quotient  <= div_quotient;
            bus.out_remainder <= div_remainder;
            bus.out_overflow  <= div_overflow;
            bus.out_valid     <= 1'b1;
            state             <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (pop) begin
              if (head_zero) begin
                bus.out_quotient  <= sat_quotient();
                bus.out_remainder <= head_num[N-1:0];
                bus.out_overflow  <= 1'b1;
                bus.out_valid     <= 1'b1;
                state             <= HOLD;
              end else begin
                div_start <= 1'b1;
                state     <= ISSUE;
              end
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: behavioural divider core, result scoreboard,
// vector table, hand-written corner sequences and a randomized run.
module tb_div_sched;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         o;
  } res_t;

  typedef struct {
    logic [2*N-1:0] num;
    logic [N-1:0]   denom;
    res_t           exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_sched_if #(.N(N)) bus ();
  logic [2*N-1:0]         div_num;
  logic [N-1:0]           div_denom;
  logic                   div_start;
  logic                   div_rdy;
  logic [N-1:0]           div_quotient;
  logic [N-1:0]           div_remainder;
  logic                   div_overflow;
  logic [$clog2(DEPTH):0] count;

  div_sched #(.N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .div_num      (div_num),
    .div_denom    (div_denom),
    .div_start    (div_start),
    .div_rdy      (div_rdy),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_overflow (div_overflow),
    .count        (count)
  );

  int   checks = 0;
  int   failures = 0;
  int   n_results = 0;
  int   start_cnt = 0;
  int   lat_fix = 3;
  bit   lat_rnd = 1'b0;
  bit   prev_pending = 1'b0;
  res_t prev_res;
  res_t last_res;
  res_t exp_q[$];

  // Reference divide: quotient saturates to all ones when it does not fit N bits.
  function automatic res_t ref_div(logic [2*N-1:0] num, logic [N-1:0] den);
    res_t r;
    int   qi;
    if (den == 0) begin
      r.q = '1;
      r.r = num[N-1:0];
      r.o = 1'b1;
    end else begin
      qi  = int'(num) / int'(den);
      r.o = (qi > (1 << N) - 1);
      r.q = r.o ? '1 : N'(qi);
      r.r = N'(int'(num) % int'(den));
    end
    return r;
  endfunction

  // Behavioural divider core: samples operands on start, answers after a latency.
  logic [7:0] d_cnt;
  logic       d_busy;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d_busy <= 1'b0;
      d_cnt  <= '0;
      div_rdy <= 1'b0;
      {div_quotient, div_remainder, div_overflow} <= '0;
    end else if (div_start) begin
      d_busy  <= 1'b1;
      div_rdy <= 1'b0;
      d_cnt   <= lat_rnd ? 8'($urandom_range(1, 6)) : 8'(lat_fix);
    end else if (d_busy) begin
      if (d_cnt <= 8'd1) begin
        d_busy  <= 1'b0;
        div_rdy <= 1'b1;
        {div_quotient, div_remainder, div_overflow} <= ref_div(div_num, div_denom);
      end else begin
        d_cnt <= d_cnt - 8'd1;
      end
    end
  end

  always @(posedge clk) if (div_start === 1'b1) start_cnt++;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One cycle: observe the handshakes about to occur on the coming edge, then advance.
  task automatic tick();
    res_t got;
    res_t e;
    got.q = bus.out_quotient;
    got.r = bus.out_remainder;
    got.o = bus.out_overflow;
    if (bus.in_valid && bus.in_ready)
      exp_q.push_back(ref_div(bus.in_num, bus.in_denom));
    if (prev_pending)
      check("hold_stable", 32'({bus.out_valid, got}), 32'({1'b1, prev_res}));
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(got), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard", 32'(got), 32'(e));
      end
      last_res = got;
      n_results++;
    end
    prev_pending = bus.out_valid && !bus.out_ready;
    prev_res     = got;
    @(negedge clk);
  endtask

  task automatic push(logic [2*N-1:0] num, logic [N-1:0] den);
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_num   = num;
    bus.in_denom = den;
    while (!bus.in_ready && k < 50) begin
      tick();
      k++;
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(int target, int budget, string name);
    int k = 0;
    while (n_results < target && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(n_results), 32'(target));
  endtask

  vec_t vecs[10];

  initial begin
    int   s0, vcyc, acc, k;
    res_t snap, snap2;

    vecs[0] = '{8'd100, 4'd7,  '{4'd14, 4'd2,  1'b0}};
    vecs[1] = '{8'd45,  4'd4,  '{4'd11, 4'd1,  1'b0}};
    vecs[2] = '{8'd200, 4'd13, '{4'd15, 4'd5,  1'b0}};
    vecs[3] = '{8'hF0,  4'd3,  '{4'hF,  4'd0,  1'b1}};
    vecs[4] = '{8'd9,   4'd2,  '{4'd4,  4'd1,  1'b0}};
    vecs[5] = '{8'd255, 4'd15, '{4'hF,  4'd0,  1'b1}};
    vecs[6] = '{8'd0,   4'd5,  '{4'd0,  4'd0,  1'b0}};
    vecs[7] = '{8'd15,  4'd1,  '{4'd15, 4'd0,  1'b0}};
    vecs[8] = '{8'd16,  4'd1,  '{4'hF,  4'd0,  1'b1}};
    vecs[9] = '{8'd239, 4'd15, '{4'd15, 4'd14, 1'b0}};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_num    = '0;
    bus.in_denom  = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_count",     32'(count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_div_start", 32'(div_start), 32'd0);
    check("rst_div_num",   32'({div_num, div_denom}), 32'd0);
    check("rst_out_data",  32'({bus.out_quotient, bus.out_remainder, bus.out_overflow}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic divide with latency and single start pulse.
    bus.out_ready = 1'b1;
    s0 = start_cnt;
    bus.in_valid = 1'b1;
    bus.in_num   = 8'd100;
    bus.in_denom = 4'd7;
    tick();
    bus.in_valid = 1'b0;
    check("lat_count_after_push", 32'(count), 32'd1);
    check("lat_no_start_yet",     32'(div_start), 32'd0);
    tick();
    check("lat_start_high",       32'(div_start), 32'd1);
    check("lat_count_after_pop",  32'(count), 32'd0);
    check("lat_div_operands",     32'({div_num, div_denom}), 32'({8'd100, 4'd7}));
    vcyc = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.out_valid) vcyc++;
      tick();
    end
    check("basic_valid_cycles", 32'(vcyc), 32'd1);
    check("basic_start_pulses", 32'(start_cnt - s0), 32'd1);
    check("basic_result",       32'(last_res), 32'({4'd14, 4'd2, 1'b0}));

    // Vector table, one request at a time.
    foreach (vecs[i]) begin
      lat_fix = 1 + (i % 4);
      push(vecs[i].num, vecs[i].denom);
      wait_results(n_results + 1, 60, $sformatf("tbl_timeout_%0d", i));
      check($sformatf("tbl_result_%0d", i), 32'(last_res), 32'(vecs[i].exp));
    end

    // Ordering with back-to-back requests.
    lat_fix = 2;
    s0 = n_results;
    push(8'd100, 4'd7);
    push(8'd45, 4'd4);
    push(8'd200, 4'd13);
    wait_results(s0 + 3, 100, "order_timeout");
    check("order_last", 32'(last_res), 32'({4'd15, 4'd5, 1'b0}));

    // Backpressure: fill the FIFO behind one in-flight op.
    bus.out_ready = 1'b0;
    lat_fix = 3;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_num   = 8'(20 + 17 * i);
      bus.in_denom = 4'(3 + i);
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("full_accepted", 32'(acc), 32'd5);
    check("full_count",    32'(count), 32'(DEPTH));
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    k = 0;
    while (!bus.out_valid && k < 50) begin
      tick();
      k++;
    end
    check("full_first_valid", 32'(bus.out_valid), 32'd1);
    snap = {bus.out_quotient, bus.out_remainder, bus.out_overflow};
    for (int i = 0; i < 10; i++) tick();
    snap2 = {bus.out_quotient, bus.out_remainder, bus.out_overflow};
    check("full_hold_10", 32'({bus.out_valid, snap2}), 32'({1'b1, snap}));
    check("full_count_held", 32'(count), 32'(DEPTH));
    bus.out_ready = 1'b1;
    s0 = n_results;
    wait_results(s0 + 5, 200, "full_drain");
    check("full_drained_count", 32'(count), 32'd0);

    // Reset while the divider is busy.
    lat_fix = 8;
    s0 = start_cnt;
    push(8'd100, 4'd7);
    push(8'd45, 4'd4);
    k = 0;
    while (start_cnt == s0 && k < 20) begin
      tick();
      k++;
    end
    tick();
    tick();
    check("midrst_pending", 32'(count != 0), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_div_start", 32'(div_start), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_count",     32'(count), 32'd0);
    exp_q.delete();
    prev_pending = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    lat_fix = 3;
    s0 = n_results;
    push(8'd9, 4'd2);
    wait_results(s0 + 1, 60, "midrst_timeout");
    check("midrst_after", 32'(last_res), 32'({4'd4, 4'd1, 1'b0}));

    // Zero denominator.
    s0 = start_cnt;
    k = n_results;
    push(8'h5A, 4'd0);
    wait_results(k + 1, 60, "zero_timeout");
    check("zero_result", 32'(last_res), 32'({4'hF, 4'hA, 1'b1}));
`ifdef DIV_ZERO_BYPASS_EN
    check("zero_starts", 32'(start_cnt - s0), 32'd0);
`else
    check("zero_starts", 32'(start_cnt - s0), 32'd1);
`endif

    // Randomized traffic against the scoreboard.
    lat_rnd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_num    = 8'($urandom);
      bus.in_denom  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      tick();
      if (count > 3'(DEPTH)) check("rnd_count_bound", 32'(count), 32'(DEPTH));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 3000) begin
      tick();
      k++;
    end
    check("rnd_drain", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("rnd_final_count", 32'(count), 32'd0);
    check("rnd_final_valid", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
